mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_div_core.sv | 46 ++++
 rtl/mdu_seq.sv | 160 ++++++++++++++++
 tb/tb_mdu_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit: funct3 codes,
// FSM states and the fixed results of the divide-by-zero / signed-overflow cases.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUO  = 32'h8000_0000;
  localparam logic [31:0] OVF_REM  = 32'h0000_0000;

  // {operand A signed, operand B signed}; MUL keeps only the low word, so sign is irrelevant
  function automatic logic [1:0] op_signs(input logic [2:0] f3);
    case (f3)
      F3_MULH, F3_DIV, F3_REM:             return 2'b11;
      F3_MULHSU:                           return 2'b10;
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU:  return 2'b00;
      default:                             return 2'b00;
    endcase
  endfunction

  // funct3[1] separates REM/REMU from DIV/DIVU
  function automatic logic [31:0] special_result(input logic [2:0] f3, input logic [31:0] a,
                                                 input logic div0);
    if (div0) return f3[1] ? a : DIV0_QUO;
    return f3[1] ? OVF_REM : OVF_QUO;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// Only present when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_div_core (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] quo_q, rem_q, dvs_q;
  logic [32:0] shifted, diff;

  // rem_q < divisor always holds, so diff[32] is a clean borrow flag
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule
`endif

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: 32-cycle shift-add multiplier and optional
// restoring divider (macro MDU_DIV_EN); without it divide ops finish at once as illegal.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_i,
  input  logic            flush,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            illegal
);

  state_t      state_q, state_d;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q, cnt_q;
  logic [63:0] prod_q, mul_p;
  logic [31:0] mcand_q, spec_res_q, a_mag, b_mag, mul_res, result;
  logic [32:0] mul_sum;
  logic [1:0]  sgn;
  logic        neg_q, spec_q, ill_q, a_neg, b_neg, advance, accept, is_special;

  assign sgn     = op_signs(funct3);
  assign a_neg   = sgn[1] & rs1_val[31];
  assign b_neg   = sgn[0] & rs2_val[31];
  assign a_mag   = a_neg ? -rs1_val : rs1_val;
  assign b_mag   = b_neg ? -rs2_val : rs2_val;
  assign advance = !flush && !hold;
  assign accept  = advance && (state_q == IDLE) && start;

`ifdef MDU_DIV_EN
  logic        div0, ovf, rneg_q;
  logic [31:0] quo, rem, div_res;

  assign div0       = (rs2_val == '0);
  assign ovf        = sgn[0] && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
  assign is_special = funct3[2] && (div0 || ovf);

  mdu_div_core u_div (
    .clk      (clk),
    .rstn     (rstn),
    .load     (accept),
    .step     (advance && (state_q == DIV)),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo      (quo),
    .rem      (rem)
  );

  // remainder follows the dividend's sign, quotient follows the sign product
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       rneg_q <= 1'b0;
    else if (accept) rneg_q <= a_neg;
  end

  assign div_res = f3_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
`else
  assign is_special = funct3[2];
`endif

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (!hold) begin
      unique case (state_q)
        IDLE: if (start) begin
          if (!funct3[2])     state_d = MUL;
          else if (is_special) state_d = DONE;
          else                state_d = DIV;
        end
        MUL, DIV: if (cnt_q == 5'd31) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // one multiplier bit per cycle: add multiplicand into the upper half, shift right
  assign mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      ill_q      <= 1'b0;
      spec_res_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q    <= funct3;
        rd_q    <= rd_i;
        cnt_q   <= '0;
        mcand_q <= a_mag;
        prod_q  <= {32'd0, b_mag};
        neg_q   <= a_neg ^ b_neg;
        spec_q  <= is_special;
`ifdef MDU_DIV_EN
        ill_q      <= 1'b0;
        spec_res_q <= special_result(funct3, rs1_val, div0);
`else
        ill_q      <= funct3[2];
        spec_res_q <= '0;
`endif
      end else if (advance && (state_q == MUL || state_q == DIV)) begin
        cnt_q <= cnt_q + 5'd1;
        if (state_q == MUL) prod_q <= {mul_sum, prod_q[31:1]};
      end
    end
  end

  assign mul_p   = neg_q ? -prod_q : prod_q;
  assign mul_res = (f3_q == F3_MUL) ? mul_p[31:0] : mul_p[63:32];

  always_comb begin
    result = mul_res;
    if (ill_q)       result = '0;
    else if (spec_q) result = spec_res_q;
`ifdef MDU_DIV_EN
    else if (f3_q[2]) result = div_res;
`endif
  end

  // DONE is held (not left) while hold is high, so the single write is re-presented later
  always_comb begin
    busy    = (state_q != IDLE);
    done    = 1'b0;
    rf_we   = 1'b0;
    illegal = 1'b0;
    rf_wa   = '0;
    rf_wd   = '0;
    if (state_q == DONE) begin
      rf_wa = rd_q;
      rf_wd = result;
      if (!hold && !flush) begin
        done    = 1'b1;
        illegal = ill_q;
        rf_we   = !ill_q && (rd_q != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed scoreboard bench for mdu_seq; expectations follow MDU_DIV_EN when defined.
module tb_mdu_seq;
  import mdu_pkg::*;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0, rs2_val = '0;
  logic [4:0]  rd_i = '0;
  logic        busy, done, rf_we, illegal;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .funct3(funct3), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .rd_i(rd_i), .flush(flush), .hold(hold), .busy(busy),
    .done(done), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .illegal(illegal)
  );

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic        ill;
    int          lat;
    bit          chk_wd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   done_cnt = 0, we_cnt = 0, d0, w0;

  always @(posedge clk) begin
    if (done === 1'b1)  done_cnt <= done_cnt + 1;
    if (rf_we === 1'b1) we_cnt   <= we_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t lit(input logic [4:0] rd, input logic [31:0] wd, input int lat);
    exp_t e;
    e.wa = rd; e.wd = wd; e.we = (rd != 5'd0); e.ill = 1'b0; e.lat = lat; e.chk_wd = 1'b1;
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd);
    exp_t e;
    logic signed [63:0] sa, sbv;
    logic [63:0] ua, ub, p;
    logic signed [31:0] a32, b32;
    sa = {{32{a[31]}}, a}; sbv = {{32{b[31]}}, b};
    ua = {32'd0, a};       ub = {32'd0, b};
    a32 = a;               b32 = b;
    e.wa = rd; e.ill = 1'b0; e.chk_wd = 1'b1; e.lat = 33; e.wd = '0;
    case (f3)
      3'd0: begin p = ua * ub;          e.wd = p[31:0];  end
      3'd1: begin p = sa * sbv;         e.wd = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); e.wd = p[63:32]; end
      3'd3: begin p = ua * ub;          e.wd = p[63:32]; end
      default: begin
`ifdef MDU_DIV_EN
        if (b == 32'd0) begin
          e.lat = 1; e.wd = f3[1] ? a : 32'hFFFF_FFFF;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lat = 1; e.wd = f3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
          case (f3)
            3'd4:    e.wd = a32 / b32;
            3'd5:    e.wd = a / b;
            3'd6:    e.wd = a32 % b32;
            default: e.wd = a % b;
          endcase
        end
`else
        e.ill = 1'b1; e.lat = 1; e.chk_wd = 1'b0;
`endif
      end
    endcase
    e.we = (rd != 5'd0) && !e.ill;
    return e;
  endfunction

  task automatic chk_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_we"}, rf_we, 0);
    check({tag, "_ill"}, illegal, 0);
    check({tag, "_wa"}, rf_wa, 0);
    check({tag, "_wd"}, rf_wd, 0);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // called right after a falling edge; start is sampled on the next rising edge (edge N)
  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_i = rd;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom()); rs1_val = $urandom(); rs2_val = $urandom();
    rd_i = 5'($urandom());
    cyc = 1;
  endtask

  task automatic issue(input exp_t e, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input string tag);
    sb.push_back(e);
    drive_start(f3, a, b, rd);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    while (done !== 1'b1 && cyc < 100) step();
    e = sb.pop_front();
    check({tag, "_lat"}, cyc, e.lat);
    check({tag, "_done"}, done, 1);
    check({tag, "_wa"}, rf_wa, e.wa);
    check({tag, "_we"}, rf_we, e.we);
    check({tag, "_ill"}, illegal, e.ill);
    if (e.chk_wd) check({tag, "_wd"}, rf_wd, e.wd);
    step();
    check({tag, "_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  logic [2:0]  tf3 [8] = '{F3_MULHSU, F3_MULH, F3_REM, F3_REMU, F3_DIV, F3_REM, F3_DIVU, F3_MUL};
  logic [31:0] ta  [8] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0,
                           32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] tb  [8] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
                           32'd1, 32'hFFFF_FFFE, 32'd3, 32'd12345};

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    #1 chk_idle("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_busy", busy, 0);

    issue(lit(5'd5, 32'hFFFF_FFEB, 33), F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, "mul");
    wait_done("mul");
    issue(lit(5'd7, 32'hFFFF_FFFE, 33), F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, "mulhu");
    wait_done("mulhu");
    issue(lit(5'd8, 32'h0, 33), F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, "mulh");
    wait_done("mulh");

`ifdef MDU_DIV_EN
    issue(lit(5'd9, 32'hFFFF_FFFD, 33), F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, "div");
    wait_done("div");
    issue(lit(5'd10, 32'hFFFF_FFFF, 33), F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, "rem");
    wait_done("rem");
    issue(lit(5'd11, 32'hFFFF_FFFF, 1), F3_DIVU, 32'd5, 32'd0, 5'd11, "divu0");
    wait_done("divu0");
    issue(lit(5'd12, 32'h8000_0000, 1), F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "divovf");
    wait_done("divovf");
`else
    issue(model(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9), F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, "div_ill");
    wait_done("div_ill");
    issue(model(F3_REMU, 32'd5, 32'd0, 5'd11), F3_REMU, 32'd5, 32'd0, 5'd11, "remu_ill");
    wait_done("remu_ill");
`endif

    // rd=0 suppresses the write; a start while busy is dropped
    d0 = done_cnt;
    issue(lit(5'd0, 32'd12, 33), F3_MUL, 32'd3, 32'd4, 5'd0, "mul_rd0");
    while (cyc < 10) step();
    start = 1'b1; funct3 = F3_MULHU; rs1_val = 32'd100; rs2_val = 32'd100; rd_i = 5'd9;
    step();
    start = 1'b0;
    wait_done("mul_rd0");
    repeat (40) step();
    check("ignored_start_dones", done_cnt - d0, 1);

    // flush mid-operation
    d0 = done_cnt; w0 = we_cnt;
`ifdef MDU_DIV_EN
    drive_start(F3_DIVU, 32'd100, 32'd7, 5'd4);
`else
    drive_start(F3_MUL, 32'd100, 32'd7, 5'd4);
`endif
    while (cyc < 5) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", busy, 0);
    repeat (40) step();
    check("flush_no_done", done_cnt - d0, 0);
    check("flush_no_we", we_cnt - w0, 0);

    // hold through cycles N+33..N+35, write re-presented at N+36
    d0 = done_cnt; w0 = we_cnt;
    drive_start(F3_MUL, 32'd1234, 32'd5678, 5'd6);
    while (cyc < 32) step();
    @(posedge clk);
    #1 hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold_done_%0d", i), done, 0);
      check($sformatf("hold_we_%0d", i), rf_we, 0);
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    @(negedge clk);
    check("hold_release_done", done, 1);
    check("hold_release_we", rf_we, 1);
    check("hold_release_wa", rf_wa, 6);
    check("hold_release_wd", rf_wd, 32'd7006652);
    step();
    check("hold_after", done, 0);
    repeat (5) step();
    check("hold_single_done", done_cnt - d0, 1);
    check("hold_single_we", we_cnt - w0, 1);

    // asynchronous reset mid-operation discards the op
    d0 = done_cnt; w0 = we_cnt;
    drive_start(F3_MUL, 32'd5, 32'd6, 5'd3);
    while (cyc < 10) step();
    #2 rstn = 1'b0;
    #1 chk_idle("rst_mid");
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) step();
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_we", we_cnt - w0, 0);

    for (int i = 0; i < 8; i++) begin
      issue(model(tf3[i], ta[i], tb[i], 5'(i + 20)), tf3[i], ta[i], tb[i], 5'(i + 20),
            $sformatf("edge%0d", i));
      wait_done($sformatf("edge%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = $urandom();
      rrd = 5'($urandom_range(1, 31));
      issue(model(rf3, ra, rb, rrd), rf3, ra, rb, rrd, $sformatf("rnd%0d", i));
      wait_done($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
